// File: rtl/mips_datapath_alu_hilo_pkg.sv
// Shared types for the HI/LO unit: ALU func encoding, HI/LO state, counter width helper.
// Included by mips_datapath_alu_hilo and its divider sub-module.
package mips_datapath_alu_hilo_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_MULS, ALU_MULU, ALU_DIVS, ALU_DIVU,
    ALU_MTHI, ALU_MTLO, ALU_MFHI, ALU_MFLO
  } alu_func_e;

  typedef enum logic [1:0] {
    HILO_IDLE,
    HILO_DIV,
    HILO_FIX
  } hilo_state_e;

  function automatic int util_math_log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Iteration counter must hold the value DATA_W.
  function automatic int hilo_cnt_w(input int data_w);
    return util_math_log2(data_w) + 1;
  endfunction

endpackage

// File: rtl/mips_datapath_alu_hilo_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, DATA_W cycles after start.
// last_cycle is high during the cycle whose closing edge produces the final bit.
module mips_datapath_alu_hilo_divider
  import mips_datapath_alu_hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              last_cycle
);

  localparam int CNT_W = hilo_cnt_w(DATA_W);

  logic [CNT_W-1:0]  count;
  logic              active;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  always_comb begin
    shifted = {rem, quo[DATA_W-1]};
    diff    = shifted - {1'b0, dvs};
  end

  assign last_cycle = active && (count == CNT_W'(DATA_W - 1));
  assign quotient   = quo;
  assign remainder  = rem;

  // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      active <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
    end else if (start) begin
      count  <= '0;
      active <= 1'b1;
      quo    <= dividend;
      rem    <= '0;
      dvs    <= divisor;
    end else if (active) begin
      if (!diff[DATA_W]) begin
        rem <= diff[DATA_W-1:0];
        quo <= {quo[DATA_W-2:0], 1'b1};
      end else begin
        rem <= shifted[DATA_W-1:0];
        quo <= {quo[DATA_W-2:0], 1'b0};
      end
      count <= count + 1'b1;
      if (last_cycle) active <= 1'b0;
    end
  end

endmodule

// File: rtl/mips_datapath_alu_hilo.sv
// HI/LO register unit: commits mult/mt* results and runs iterative signed/unsigned divide.
// Optional same-cycle forwarding of Mul*/Mt* writes: MIPS_DATAPATH_ALU_HILO_FORWARD_EN.
module mips_datapath_alu_hilo
  import mips_datapath_alu_hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic              flush,
  input  alu_func_e         func,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] res_lo,
  input  logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] reg_lo,
  output logic [DATA_W-1:0] reg_hi,
  output logic              busy,
  output logic              done
);

  hilo_state_e       state, next_state;
  logic [DATA_W-1:0] lo_q, hi_q;
  logic [DATA_W-1:0] dividend_q;
  logic              q_neg_q, r_neg_q, div_zero_q;

  logic              idle_op, accept_div, wr_lo, wr_hi, commit, div_signed;
  logic [DATA_W-1:0] mag1, mag2, quotient, remainder, fix_lo, fix_hi;
  logic              last_cycle;

  assign idle_op    = (state == HILO_IDLE) && valid && !flush && !reset;
  assign accept_div = idle_op && (func == ALU_DIVS || func == ALU_DIVU);
  assign wr_lo      = idle_op && (func == ALU_MULS || func == ALU_MULU || func == ALU_MTLO);
  assign wr_hi      = idle_op && (func == ALU_MULS || func == ALU_MULU || func == ALU_MTHI);
  assign div_signed = (func == ALU_DIVS);
  assign mag1       = (div_signed && data1[DATA_W-1]) ? -data1 : data1;
  assign mag2       = (div_signed && data2[DATA_W-1]) ? -data2 : data2;
  assign commit     = (state == HILO_FIX) && !flush;

  mips_datapath_alu_hilo_divider #(.DATA_W(DATA_W)) u_divider (
    .clock      (clock),
    .reset      (reset),
    .start      (accept_div),
    .dividend   (mag1),
    .divisor    (mag2),
    .quotient   (quotient),
    .remainder  (remainder),
    .last_cycle (last_cycle)
  );

  // Divide-by-zero bypasses sign fixing: LO all ones, HI the raw dividend.
  assign fix_lo = div_zero_q ? '1         : (q_neg_q ? -quotient  : quotient);
  assign fix_hi = div_zero_q ? dividend_q : (r_neg_q ? -remainder : remainder);

  always_comb begin
    // NOTE: default assigned first so no branch leaves next_state unassigned (no latch).
    next_state = state;
    unique case (state)
      HILO_IDLE: if (accept_div) next_state = HILO_DIV;
      HILO_DIV:  if (last_cycle) next_state = HILO_FIX;
      HILO_FIX:  next_state = HILO_IDLE;
      default:   next_state = HILO_IDLE;
    endcase
    if (flush) next_state = HILO_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= HILO_IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dividend_q <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != HILO_IDLE);
      done  <= commit;
      if (commit) begin
        lo_q <= fix_lo;
        hi_q <= fix_hi;
      end else begin
        if (wr_lo) lo_q <= res_lo;
        if (wr_hi) hi_q <= res_hi;
      end
      if (accept_div) begin
        dividend_q <= data1;
        q_neg_q    <= div_signed && (data1[DATA_W-1] ^ data2[DATA_W-1]);
        r_neg_q    <= div_signed && data1[DATA_W-1];
        div_zero_q <= (data2 == '0);
      end
    end
  end

`ifdef MIPS_DATAPATH_ALU_HILO_FORWARD_EN
  assign reg_lo = wr_lo ? res_lo : lo_q;
  assign reg_hi = wr_hi ? res_hi : hi_q;
`else
  assign reg_lo = lo_q;
  assign reg_hi = hi_q;
`endif

endmodule

// File: tb/tb_mips_datapath_alu_hilo.sv
// Self-checking bench for mips_datapath_alu_hilo: directed cases plus random ops
// checked against an arithmetic HI/LO model with a divide countdown.
module tb_mips_datapath_alu_hilo;
  import mips_datapath_alu_hilo_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, valid, flush;
  alu_func_e    func;
  logic [W-1:0] data1, data2, res_lo, res_hi;
  logic [W-1:0] reg_lo, reg_hi;
  logic         busy, done;

  always #5 clock = ~clock;

  mips_datapath_alu_hilo #(.DATA_W(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .valid  (valid),
    .flush  (flush),
    .func   (func),
    .data1  (data1),
    .data2  (data2),
    .res_lo (res_lo),
    .res_hi (res_hi),
    .reg_lo (reg_lo),
    .reg_hi (reg_hi),
    .busy   (busy),
    .done   (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural HI/LO plus cycles left until a divide commits.
  logic [W-1:0] m_lo = '0, m_hi = '0, p_lo = '0, p_hi = '0;
  int           m_left = 0;
  logic         m_done = 1'b0;
  int           done_seen = 0;
  int           busy_seen = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void div_ref(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  function automatic bit writes_lo(input alu_func_e f);
    return f == ALU_MULS || f == ALU_MULU || f == ALU_MTLO;
  endfunction

  function automatic bit writes_hi(input alu_func_e f);
    return f == ALU_MULS || f == ALU_MULU || f == ALU_MTHI;
  endfunction

  // Check outputs mid-cycle, advance the model with this cycle's inputs, step one edge.
  task automatic tick();
    logic [W-1:0] exp_lo, exp_hi;
    @(negedge clock);
    exp_lo = m_lo;
    exp_hi = m_hi;
`ifdef MIPS_DATAPATH_ALU_HILO_FORWARD_EN
    if (!reset && !flush && valid && m_left == 0) begin
      if (writes_lo(func)) exp_lo = res_lo;
      if (writes_hi(func)) exp_hi = res_hi;
    end
`endif
    check("busy", {31'b0, busy}, {31'b0, (m_left > 0)});
    check("done", {31'b0, done}, {31'b0, m_done});
    check("reg_lo", reg_lo, exp_lo);
    check("reg_hi", reg_hi, exp_hi);
    if (done) done_seen++;
    if (busy) busy_seen++;

    if (reset) begin
      m_lo = '0; m_hi = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_lo = p_lo; m_hi = p_hi; m_done = 1'b1;
          end
        end
      end else if (valid && !flush) begin
        case (func)
          ALU_MULS, ALU_MULU: begin m_lo = res_lo; m_hi = res_hi; end
          ALU_MTLO: m_lo = res_lo;
          ALU_MTHI: m_hi = res_hi;
          ALU_DIVS, ALU_DIVU: begin
            div_ref(func == ALU_DIVS, data1, data2, p_lo, p_hi);
            m_left = W + 1;
          end
          default: ;
        endcase
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic op(input alu_func_e f, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] rl, input logic [W-1:0] rh);
    valid = 1'b1; func = f; data1 = a; data2 = b; res_lo = rl; res_hi = rh;
    tick();
    valid = 1'b0;
  endtask

  // Run until the divide finishes (bounded), then one more cycle to see done.
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || m_left > 0) && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", {31'b0, busy}, 32'd0);
    tick();
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; flush = 1'b0; func = ALU_ADD;
    data1 = '0; data2 = '0; res_lo = '0; res_hi = '0;
    @(posedge clock); #1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_lo", reg_lo, 32'd0);
    check("rst_hi", reg_hi, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);

    op(ALU_MULU, 32'd0, 32'd0, 32'd5, 32'd7);
    check("mulu_lo", reg_lo, 32'd5);
    check("mulu_hi", reg_hi, 32'd7);
    check("mulu_busy", {31'b0, busy}, 32'd0);

    done_seen = 0; busy_seen = 0;
    op(ALU_DIVU, 32'd100, 32'd7, 32'd0, 32'd0);
    wait_idle(60);
    check("divu_busy_cycles", busy_seen, 32'd33);
    check("divu_done_pulses", done_seen, 32'd1);
    check("divu_lo", reg_lo, 32'd14);
    check("divu_hi", reg_hi, 32'd2);

    op(ALU_DIVU, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'd0);
    wait_idle(60);
    check("divu_max_lo", reg_lo, 32'h2492_4924);
    check("divu_max_hi", reg_hi, 32'd3);

    op(ALU_DIVS, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
    wait_idle(60);
    check("divs_neg_lo", reg_lo, 32'hFFFF_FFFD);
    check("divs_neg_hi", reg_hi, 32'hFFFF_FFFF);

    op(ALU_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
    wait_idle(60);
    check("divs_ovf_lo", reg_lo, 32'h8000_0000);
    check("divs_ovf_hi", reg_hi, 32'd0);

    op(ALU_DIVS, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0);
    wait_idle(60);
    check("divs_zero_lo", reg_lo, 32'hFFFF_FFFF);
    check("divs_zero_hi", reg_hi, 32'hFFFF_FFF0);

    op(ALU_DIVU, 32'd9, 32'd0, 32'd0, 32'd0);
    wait_idle(60);
    check("divu_zero_lo", reg_lo, 32'hFFFF_FFFF);
    check("divu_zero_hi", reg_hi, 32'd9);

    // Flush at cycle 10 of a divide, with an Mthi attempted inside the busy window.
    done_seen = 0;
    op(ALU_DIVU, 32'd1000, 32'd3, 32'd0, 32'd0);
    for (int i = 1; i < 10; i++) begin
      if (i == 5) op(ALU_MTHI, 32'd0, 32'd0, 32'd0, 32'h1234);
      else tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_lo", reg_lo, 32'hFFFF_FFFF);
    check("flush_hi", reg_hi, 32'd9);
    for (int i = 0; i < 40; i++) tick();
    check("flush_no_done", done_seen, 32'd0);

    // Mtlo: visible same cycle with forwarding, one edge later without.
    valid = 1'b1; func = ALU_MTLO; res_lo = 32'h0000_ABCD; data1 = '0; data2 = '0;
    #2;
`ifdef MIPS_DATAPATH_ALU_HILO_FORWARD_EN
    check("mtlo_same_cycle", reg_lo, 32'h0000_ABCD);
`else
    check("mtlo_same_cycle", reg_lo, 32'hFFFF_FFFF);
`endif
    tick();
    valid = 1'b0;
    check("mtlo_next_cycle", reg_lo, 32'h0000_ABCD);

    // Random traffic, including ops while busy, flushes and resets.
    for (int c = 0; c < 4000; c++) begin
      valid  = ($urandom_range(0, 9) < 7);
      func   = alu_func_e'(5'($urandom_range(0, 20)));
      flush  = ($urandom_range(0, 59) == 0);
      reset  = ($urandom_range(0, 299) == 0);
      res_lo = $urandom();
      res_hi = $urandom();
      case ($urandom_range(0, 5))
        0:       data1 = 32'h8000_0000;
        1:       data1 = $urandom_range(0, 100);
        default: data1 = $urandom();
      endcase
      case ($urandom_range(0, 7))
        0:       data2 = '0;
        1:       data2 = 32'hFFFF_FFFF;
        2:       data2 = $urandom_range(1, 15);
        3:       data2 = -($urandom_range(1, 15));
        default: data2 = $urandom();
      endcase
      tick();
    end
    valid = 1'b0; flush = 1'b0; reset = 1'b0;
    wait_idle(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
